spi_reg_access_arb: RTL and testbench

Arbiter and sequencer that shares the byte-addressed SPI slave register file (NUM_BYTES bytes, packed 4 per 32-bit word) between the APB bus and the SPI slave engine.
- The SPI engine runs in the SPI clock domain and uses a 4-phase req/ack handshake; this block synchronises it into sys_clk.
- Only one register-file access is issued per cycle, so no SPI write is ever dropped on an APB collision.
- Sits between the APB slave decode, the SPI frame engine and the register storage.

---
 rtl/spi_reg_access_arb.sv | 95 +++++++++
 tb/tb_spi_reg_access_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_access_arb.sv
// spi_reg_access_arb: shares the byte-addressed register file between APB and the SPI engine,
// synchronising the SPI 4-phase req/ack handshake into sys_clk and arbitrating round-robin.
module spi_reg_access_arb #(
    parameter int NUM_BYTES = 16,
    parameter int CNT_W = 8
) (
    input  logic             sys_clk,
    input  logic             rst_b,
    input  logic             apb_psel,
    input  logic             apb_penable,
    input  logic             apb_pwrite,
    input  logic [7:0]       apb_paddr,
    input  logic [31:0]      apb_pwdata,
    output logic             apb_pready,
    output logic [31:0]      apb_prdata,
    input  logic             spi_req,
    input  logic             spi_rw,
    input  logic [7:0]       spi_addr,
    input  logic [7:0]       spi_wdata,
    output logic             spi_ack,
    output logic [7:0]       spi_rdata,
    output logic             rf_wr_en,
    output logic             rf_rd_en,
    output logic [5:0]       rf_addr,
    output logic [3:0]       rf_be,
    output logic [31:0]      rf_wdata,
    input  logic [31:0]      rf_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam logic [6:0] NUM_WORDS = 7'(NUM_BYTES / 4);
    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;
    state_t state;
    logic sync1, sync2, req_d, last_spi, p_rw;
    logic [7:0] p_addr, p_wdata, spi_byte;
    logic apb_req, spi_pend, apb_gnt, spi_gnt, apb_ok, spi_ok, rise, fall_seen, unused_bits;
    always_comb begin
        apb_req = apb_psel & apb_penable;
        spi_pend = state == PEND;
        apb_gnt = apb_req & (~spi_pend | last_spi);
        spi_gnt = spi_pend & ~apb_gnt;
        apb_ok = {1'b0, apb_paddr[7:2]} < NUM_WORDS;
        spi_ok = {1'b0, p_addr[7:2]} < NUM_WORDS;
        rise = sync2 & ~req_d;
        fall_seen = ~sync2;
        unused_bits = ^apb_paddr[1:0];
        rf_addr = apb_gnt ? apb_paddr[7:2] : p_addr[7:2];
        rf_wr_en = apb_gnt ? apb_pwrite & apb_ok : spi_gnt & p_rw & spi_ok;
        rf_rd_en = apb_gnt ? ~apb_pwrite & apb_ok : spi_gnt & ~p_rw & spi_ok;
        rf_be = apb_gnt ? 4'hF : 4'b0001 << p_addr[1:0];
        rf_wdata = apb_gnt ? apb_pwdata : {4{p_wdata}};
        apb_pready = apb_gnt;
        apb_prdata = (apb_gnt & ~apb_pwrite & apb_ok) ? rf_rdata : '0;
        spi_byte = spi_ok ? 8'(rf_rdata >> {p_addr[1:0], 3'b000}) : '0;
    end
    // last_spi resets high so APB wins the first tie
    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            req_d <= 1'b0;
            last_spi <= 1'b1;
            p_rw <= 1'b0;
            p_addr <= '0;
            p_wdata <= '0;
            spi_ack <= 1'b0;
            spi_rdata <= '0;
            conflict_cnt <= '0;
        end else begin
            sync1 <= spi_req;
            sync2 <= sync1;
            req_d <= sync2;
            if (apb_gnt | spi_gnt) last_spi <= spi_gnt;
            if (apb_req & spi_pend & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 1'b1;
            case (state)
                IDLE: if (rise) begin
                    p_rw <= spi_rw;
                    p_addr <= spi_addr;
                    p_wdata <= spi_wdata;
                    state <= PEND;
                end
                PEND: if (spi_gnt) begin
                    spi_ack <= 1'b1;
                    if (!p_rw) spi_rdata <= spi_byte;
                    state <= ACK;
                end
                ACK: if (fall_seen) begin
                    spi_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_access_arb.sv
// tb_spi_reg_access_arb: directed and randomized checks of the APB/SPI register-file arbiter
// against a word-array reference model of the register file.
module tb_spi_reg_access_arb;
    localparam int NW = 4;
    logic sys_clk = 1'b0;
    logic rst_b, apb_psel, apb_penable, apb_pwrite, apb_pready;
    logic [7:0] apb_paddr;
    logic [31:0] apb_pwdata, apb_prdata;
    logic spi_req, spi_rw, spi_ack, rf_wr_en, rf_rd_en;
    logic [7:0] spi_addr, spi_wdata, spi_rdata, conflict_cnt;
    logic [5:0] rf_addr;
    logic [3:0] rf_be;
    logic [31:0] rf_wdata, rf_rdata;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic load = 1'b1;
    int wr_cnt = 0;
    logic [5:0] lw_addr;
    logic [3:0] lw_be;
    logic [31:0] lw_data;
    int nvec = 0;
    int nfail = 0;

    always #5 sys_clk = ~sys_clk;

    spi_reg_access_arb #(.NUM_BYTES(16), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .rst_b(rst_b),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pready(apb_pready),
        .apb_prdata(apb_prdata),
        .spi_req(spi_req), .spi_rw(spi_rw), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_ack(spi_ack), .spi_rdata(spi_rdata),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr), .rf_be(rf_be),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .conflict_cnt(conflict_cnt)
    );

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((4 * i + k) * 17);
        return w;
    endfunction

    // register storage driven only by the DUT's strobes
    assign rf_rdata = mem[rf_addr];
    always @(posedge sys_clk) begin
        if (load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (rf_wr_en) begin
            for (int k = 0; k < 4; k++) if (rf_be[k]) mem[rf_addr][8*k +: 8] <= rf_wdata[8*k +: 8];
            wr_cnt <= wr_cnt + 1;
            lw_addr <= rf_addr;
            lw_be <= rf_be;
            lw_data <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_apb_rd(input logic [7:0] a);
        return (int'(a[7:2]) < NW) ? ref_mem[a[7:2]] : 32'h0;
    endfunction

    function automatic logic [7:0] m_spi_rd(input logic [7:0] a);
        return (int'(a[7:2]) < NW) ? 8'(ref_mem[a[7:2]] >> (8 * int'(a[1:0]))) : 8'h0;
    endfunction

    task automatic m_apb_wr(input logic [7:0] a, input logic [31:0] d);
        if (int'(a[7:2]) < NW) ref_mem[a[7:2]] = d;
    endtask

    task automatic m_spi_wr(input logic [7:0] a, input logic [7:0] b);
        if (int'(a[7:2]) < NW) ref_mem[a[7:2]][8*int'(a[1:0]) +: 8] = b;
    endtask

    // call at a negedge; returns at the negedge after the completing edge
    task automatic apb_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int waits);
        bit done = 0;
        waits = 0;
        rd = '0;
        apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = wr; apb_paddr = a; apb_pwdata = d;
        @(negedge sys_clk);
        apb_penable = 1'b1;
        for (int k = 0; k < 16 && !done; k++) begin
            #1;
            if (apb_pready) begin
                rd = apb_prdata;
                done = 1;
            end else begin
                waits++;
                @(negedge sys_clk);
            end
        end
        chk("apb_pready_timeout", 32'(done), 32'd1);
        @(negedge sys_clk);
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic spi_go(input bit rw, input logic [7:0] a, input logic [7:0] d);
        spi_rw = rw; spi_addr = a; spi_wdata = d; spi_req = 1'b1;
    endtask

    task automatic spi_wait(input logic lvl, output int edges);
        edges = 0;
        while (spi_ack !== lvl && edges < 20) begin
            @(posedge sys_clk);
            #1;
            edges++;
        end
        chk("spi_ack_timeout", 32'(spi_ack), 32'(lvl));
    endtask

    task automatic spi_txn(input bit rw, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int up, output int down);
        spi_go(rw, a, d);
        spi_wait(1'b1, up);
        rd = spi_rdata;
        @(negedge sys_clk);
        spi_req = 1'b0;
        spi_wait(1'b0, down);
        @(negedge sys_clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0] srd;
        int w, up, down, w0;
        rst_b = 1'b0;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = '0; apb_pwdata = '0;
        spi_req = 1'b0; spi_rw = 1'b0; spi_addr = '0; spi_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge sys_clk);
        load = 1'b0;
        chk("rst_spi_ack", 32'(spi_ack), 32'd0);
        chk("rst_spi_rdata", 32'(spi_rdata), 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        rst_b = 1'b1;
        @(negedge sys_clk);

        apb_xfer(1'b0, 8'h00, 32'h0, rd, w);
        chk("apb_rd0_data", rd, 32'h33221100);
        chk("apb_rd0_waits", 32'(w), 32'd0);
        chk("apb_rd0_spi_ack", 32'(spi_ack), 32'd0);
        chk("apb_rd0_conflict", 32'(conflict_cnt), 32'd0);

        w0 = wr_cnt;
        spi_txn(1'b1, 8'h05, 8'hA5, srd, up, down);
        m_spi_wr(8'h05, 8'hA5);
        chk("spi_wr_rise_lat", 32'(up), 32'd4);
        chk("spi_wr_fall_lat", 32'(down), 32'd3);
        chk("spi_wr_strobes", 32'(wr_cnt - w0), 32'd1);
        chk("spi_wr_rf_addr", 32'(lw_addr), 32'd1);
        chk("spi_wr_rf_be", 32'(lw_be), 32'b0010);
        chk("spi_wr_rf_wdata", lw_data, 32'hA5A5A5A5);
        chk("spi_wr_word1", mem[1], ref_mem[1]);

        spi_txn(1'b0, 8'h0E, 8'h00, srd, up, down);
        chk("spi_rd_0e", 32'(srd), 32'hEE);

        spi_go(1'b1, 8'h09, 8'h5A);
        repeat (2) @(negedge sys_clk);
        apb_xfer(1'b1, 8'h08, 32'h12345678, rd, w);
        m_apb_wr(8'h08, 32'h12345678);
        m_spi_wr(8'h09, 8'h5A);
        chk("coll1_apb_waits", 32'(w), 32'd0);
        spi_wait(1'b1, up);
        chk("coll1_conflict", 32'(conflict_cnt), 32'd1);
        @(negedge sys_clk);
        spi_req = 1'b0;
        spi_wait(1'b0, down);
        @(negedge sys_clk);
        chk("coll1_word2", mem[2], 32'h12345A78);
        chk("coll1_word2_model", mem[2], ref_mem[2]);

        apb_xfer(1'b0, 8'h08, 32'h0, rd, w);
        chk("apb_rd2", rd, m_apb_rd(8'h08));

        spi_go(1'b1, 8'h09, 8'h77);
        repeat (2) @(negedge sys_clk);
        apb_xfer(1'b1, 8'h08, 32'hCAFEF00D, rd, w);
        m_spi_wr(8'h09, 8'h77);
        m_apb_wr(8'h08, 32'hCAFEF00D);
        chk("coll2_apb_waits", 32'(w), 32'd1);
        spi_wait(1'b1, up);
        chk("coll2_conflict", 32'(conflict_cnt), 32'd2);
        @(negedge sys_clk);
        spi_req = 1'b0;
        spi_wait(1'b0, down);
        @(negedge sys_clk);
        chk("coll2_word2", mem[2], ref_mem[2]);

        w0 = wr_cnt;
        spi_txn(1'b1, 8'h40, 8'h99, srd, up, down);
        chk("oor_spi_wr_ack", 32'(up), 32'd4);
        chk("oor_spi_wr_strobes", 32'(wr_cnt - w0), 32'd0);
        apb_xfer(1'b0, 8'h20, 32'h0, rd, w);
        chk("oor_apb_rd_waits", 32'(w), 32'd0);
        chk("oor_apb_rd_data", rd, 32'h0);
        spi_txn(1'b0, 8'h41, 8'h00, srd, up, down);
        chk("oor_spi_rd_data", 32'(srd), 32'h0);

        spi_go(1'b1, 8'h06, 8'h3C);
        spi_wait(1'b1, up);
        @(negedge sys_clk);
        w0 = wr_cnt;
        rst_b = 1'b0;
        #1;
        chk("midrst_spi_ack", 32'(spi_ack), 32'd0);
        chk("midrst_conflict", 32'(conflict_cnt), 32'd0);
        @(negedge sys_clk);
        rst_b = 1'b1;
        spi_wait(1'b1, up);
        chk("midrst_reexec_lat", 32'(up), 32'd4);
        chk("midrst_reexec_strobes", 32'(wr_cnt - w0), 32'd1);
        @(negedge sys_clk);
        spi_req = 1'b0;
        spi_wait(1'b0, down);
        @(negedge sys_clk);
        m_spi_wr(8'h06, 8'h3C);
        chk("midrst_word1", mem[1], ref_mem[1]);

        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [7:0] a;
            logic [31:0] d;
            kind = int'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 23));
            d = $urandom;
            w0 = wr_cnt;
            if (kind == 0) begin
                apb_xfer(1'b0, a, 32'h0, rd, w);
                chk("rnd_apb_rd", rd, m_apb_rd(a));
            end else if (kind == 1) begin
                apb_xfer(1'b1, a, d, rd, w);
                m_apb_wr(a, d);
                chk("rnd_apb_wr_strobes", 32'(wr_cnt - w0), (int'(a[7:2]) < NW) ? 32'd1 : 32'd0);
            end else if (kind == 2) begin
                spi_txn(1'b0, a, 8'h00, srd, up, down);
                chk("rnd_spi_rd", 32'(srd), 32'(m_spi_rd(a)));
            end else begin
                spi_txn(1'b1, a, d[7:0], srd, up, down);
                m_spi_wr(a, d[7:0]);
                chk("rnd_spi_wr_strobes", 32'(wr_cnt - w0), (int'(a[7:2]) < NW) ? 32'd1 : 32'd0);
            end
        end
        for (int i = 0; i < NW; i++) chk($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
